// File: rtl/engine_arbiter.sv
// engine_arbiter: round-robin sharing of one computation engine among N
// requesters, with start/done sequencing and a BUSY-state watchdog.
module engine_arbiter #(
   parameter int N   = 4,
   parameter int DW  = 8,
   parameter int RW  = 16,
   parameter int TMO = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    req,
   input  logic [N*DW-1:0] opnd,
   output logic [N-1:0]    gnt,
   output logic [N-1:0]    ack,
   output logic [RW-1:0]   res,
   output logic            err,
   output logic            busy,
   output logic            engStart,
   output logic [DW-1:0]   engOpnd,
   input  logic            engDone,
   input  logic [RW-1:0]   engRes
);
   localparam int PW = (N > 1) ? $clog2(N) : 1;
   localparam int TW = (TMO > 1) ? $clog2(TMO) : 1;
   localparam logic [PW-1:0] LAST = PW'(N - 1);
   localparam logic [TW-1:0] TLIM = TW'(TMO - 1);
   localparam logic [PW:0]   NW   = (PW + 1)'(N);

   typedef enum logic [1:0] {IDLE, START, BUSY, RESP} state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] ptr_q, ptr_d;
   logic [PW-1:0] sel_q, sel_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [RW-1:0] res_q, res_d;
   logic          err_q, err_d;
   logic [DW-1:0] opnd_q, opnd_d;

   logic          hit;
   logic [PW-1:0] pick;
   logic [DW-1:0] pick_opnd;
   logic [N-1:0]  sel_oh;

   // Scan ptr, ptr+1, ... wrapping, and take the first active request.
   always_comb begin
      logic [PW:0] sum;
      logic [PW-1:0] cand;
      hit  = 1'b0;
      pick = '0;
      sum  = '0;
      cand = '0;
      for (int k = 0; k < N; k++) begin
         sum = {1'b0, ptr_q} + (PW + 1)'(k);
         if (sum >= NW) begin
            sum = sum - NW;
         end
         cand = sum[PW-1:0];
         if (!hit && req[cand]) begin
            hit  = 1'b1;
            pick = cand;
         end
      end
   end

   always_comb begin
      pick_opnd = '0;
      for (int i = 0; i < N; i++) begin
         if (pick == PW'(i)) begin
            pick_opnd = opnd[i*DW +: DW];
         end
      end
   end

   always_comb begin
      sel_oh = '0;
      for (int i = 0; i < N; i++) begin
         sel_oh[i] = (sel_q == PW'(i));
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      sel_d   = sel_q;
      timer_d = timer_q;
      res_d   = res_q;
      err_d   = err_q;
      opnd_d  = opnd_q;
      unique case (state_q)
         IDLE: begin
            if (hit) begin
               state_d = START;
               sel_d   = pick;
               opnd_d  = pick_opnd;
               timer_d = '0;
            end
         end
         START: begin
            state_d = BUSY;
         end
         BUSY: begin
            timer_d = timer_q + TW'(1);
            // A done arriving on the last allowed cycle still counts as success.
            if (engDone) begin
               res_d   = engRes;
               err_d   = 1'b0;
               state_d = RESP;
            end else if (timer_q == TLIM) begin
               res_d   = '0;
               err_d   = 1'b1;
               state_d = RESP;
            end
         end
         RESP: begin
            ptr_d   = (sel_q == LAST) ? '0 : sel_q + PW'(1);
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         sel_q   <= '0;
         timer_q <= '0;
         res_q   <= '0;
         err_q   <= 1'b0;
         opnd_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         sel_q   <= sel_d;
         timer_q <= timer_d;
         res_q   <= res_d;
         err_q   <= err_d;
         opnd_q  <= opnd_d;
      end
   end

   assign gnt      = (state_q != IDLE) ? sel_oh : '0;
   assign ack      = (state_q == RESP) ? sel_oh : '0;
   assign busy     = (state_q != IDLE);
   assign engStart = (state_q == START);
   assign res      = res_q;
   assign err      = err_q;
   assign engOpnd  = opnd_q;

endmodule

// File: tb/tb_engine_arbiter.sv
// tb_engine_arbiter: directed scenarios plus random traffic, all checked
// every cycle against a transaction-level model of the arbiter.
module tb_engine_arbiter;
   localparam int N   = 4;
   localparam int DW  = 8;
   localparam int RW  = 16;
   localparam int TMO = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req;
   logic [N*DW-1:0] opnd;
   logic [N-1:0]    gnt;
   logic [N-1:0]    ack;
   logic [RW-1:0]   res;
   logic            err;
   logic            busy;
   logic            engStart;
   logic [DW-1:0]   engOpnd;
   logic            engDone;
   logic [RW-1:0]   engRes;

   always #5 clk = ~clk;

   engine_arbiter #(.N(N), .DW(DW), .RW(RW), .TMO(TMO)) dut (
      .clk(clk), .rst(rst), .req(req), .opnd(opnd),
      .gnt(gnt), .ack(ack), .res(res), .err(err), .busy(busy),
      .engStart(engStart), .engOpnd(engOpnd),
      .engDone(engDone), .engRes(engRes)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Model phase: 0 idle, 1 start, 2 engine running, 3 respond.
   int            m_ph  = 0;
   int            m_b   = 0;
   int            m_ptr = 0;
   int            m_sel = 0;
   logic [RW-1:0] m_res = '0;
   logic          m_err = 1'b0;
   logic [DW-1:0] m_opnd = '0;

   always @(negedge clk) begin
      logic [N-1:0] e_oh;
      logic         found;
      int           i;
      e_oh = N'(1) << m_sel;
      chk("gnt", 32'(gnt), 32'((m_ph != 0) ? e_oh : '0));
      chk("ack", 32'(ack), 32'((m_ph == 3) ? e_oh : '0));
      chk("busy", 32'(busy), 32'(m_ph != 0));
      chk("engStart", 32'(engStart), 32'(m_ph == 1));
      chk("res", 32'(res), 32'(m_res));
      chk("err", 32'(err), 32'(m_err));
      chk("engOpnd", 32'(engOpnd), 32'(m_opnd));
      if (rst) begin
         m_ph = 0; m_b = 0; m_ptr = 0; m_sel = 0;
         m_res = '0; m_err = 1'b0; m_opnd = '0;
      end else begin
         case (m_ph)
            0: if (req != '0) begin
               found = 1'b0;
               for (int k = 0; k < N; k++) begin
                  i = (m_ptr + k) % N;
                  if (!found && req[i]) begin
                     found = 1'b1;
                     m_sel = i;
                  end
               end
               m_opnd = DW'(opnd >> (m_sel * DW));
               m_b = 0;
               m_ph = 1;
            end
            1: m_ph = 2;
            2: begin
               if (engDone) begin
                  m_res = engRes; m_err = 1'b0; m_ph = 3;
               end else if (m_b == TMO - 1) begin
                  m_res = '0; m_err = 1'b1; m_ph = 3;
               end else begin
                  m_b++;
               end
            end
            default: begin
               m_ptr = (m_sel + 1) % N;
               m_ph = 0;
            end
         endcase
      end
   end

   // Run one transaction starting in an IDLE cycle with req already set.
   // lat: BUSY cycle index at which done arrives (>= TMO means never).
   task automatic txn(input int lat, input logic [RW-1:0] rv,
                      input bit spur, input bit drop,
                      input logic [N-1:0] rnext,
                      output logic [N-1:0] g, output logic es,
                      output logic [DW-1:0] o, output logic [N-1:0] a,
                      output logic e, output logic [RW-1:0] r,
                      output int nc, output logic [N-1:0] a2);
      nc = 0;
      step(); nc++;
      g = gnt; es = engStart; o = engOpnd;
      engDone = spur;
      engRes = ~rv;
      if (drop) req = '0;
      for (int b = 0; b < TMO; b++) begin
         step(); nc++;
         engDone = (b == lat);
         engRes = (b == lat) ? rv : ~rv;
         if (b == lat) break;
      end
      step(); nc++;
      engDone = 1'b0;
      a = ack; e = err; r = res;
      req = rnext;
      step();
      a2 = ack;
   endtask

   logic [N-1:0]  g, a, a2, pend;
   logic          es, e;
   logic [DW-1:0] o;
   logic [RW-1:0] r;
   int            nc;
   logic [N-1:0]  rr_exp [5];

   initial begin
      rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
      rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
      rst = 1'b1; req = '0; opnd = '0; engDone = 1'b0; engRes = '0;
      step(); step();
      rst = 1'b0;
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_res", 32'(res), 32'h0);
      chk("rst_engOpnd", 32'(engOpnd), 32'h0);

      // single request, done at cycle 3
      opnd[7:0] = 8'h2A;
      req = 4'b0001;
      txn(1, 16'h1234, 1'b0, 1'b0, 4'b0000, g, es, o, a, e, r, nc, a2);
      chk("t1_gnt", 32'(g), 32'h1);
      chk("t1_start", 32'(es), 32'h1);
      chk("t1_opnd", 32'(o), 32'h2A);
      chk("t1_ack", 32'(a), 32'h1);
      chk("t1_res", 32'(r), 32'h1234);
      chk("t1_err", 32'(e), 32'h0);
      chk("t1_lat", 32'(nc), 32'd4);
      chk("t1_ackw", 32'(a2), 32'h0);

      // round robin from ptr 0 with all requests held
      rst = 1'b1; step(); rst = 1'b0;
      opnd = 32'h44332211;
      req = 4'b1111;
      for (int t = 0; t < 5; t++) begin
         txn(1, 16'(t + 1), 1'b0, 1'b0, 4'b1111, g, es, o, a, e, r, nc, a2);
         chk("rr_gnt", 32'(g), 32'(rr_exp[t]));
         chk("rr_ack", 32'(a), 32'(rr_exp[t]));
         chk("rr_ackw", 32'(a2), 32'h0);
      end

      // pointer skip: serve 1, then 0101 gives 2 then 0
      txn(1, 16'h0101, 1'b0, 1'b0, 4'b0101, g, es, o, a, e, r, nc, a2);
      chk("ps_gnt1", 32'(g), 32'h2);
      txn(1, 16'h0202, 1'b0, 1'b0, 4'b0101, g, es, o, a, e, r, nc, a2);
      chk("ps_gnt2", 32'(g), 32'h4);
      chk("ps_opnd2", 32'(o), 32'h33);
      txn(1, 16'h0303, 1'b0, 1'b0, 4'b0000, g, es, o, a, e, r, nc, a2);
      chk("ps_gnt0", 32'(g), 32'h1);

      // timeout boundary
      req = 4'b0100;
      txn(99, 16'hCAFE, 1'b0, 1'b0, 4'b0100, g, es, o, a, e, r, nc, a2);
      chk("to_ack", 32'(a), 32'h4);
      chk("to_err", 32'(e), 32'h1);
      chk("to_res", 32'(r), 32'h0);
      chk("to_lat", 32'(nc), 32'd6);
      txn(3, 16'hBEEF, 1'b0, 1'b0, 4'b0001, g, es, o, a, e, r, nc, a2);
      chk("tl_err", 32'(e), 32'h0);
      chk("tl_res", 32'(r), 32'hBEEF);
      chk("tl_lat", 32'(nc), 32'd6);

      // spurious done in START is ignored
      txn(2, 16'h5A5A, 1'b1, 1'b0, 4'b0010, g, es, o, a, e, r, nc, a2);
      chk("sp_res", 32'(r), 32'h5A5A);
      chk("sp_lat", 32'(nc), 32'd5);
      // requester drops req after grant
      txn(0, 16'h0F0F, 1'b0, 1'b1, 4'b0000, g, es, o, a, e, r, nc, a2);
      chk("dr_ack", 32'(a), 32'h2);
      chk("dr_lat", 32'(nc), 32'd3);

      // reset mid-BUSY
      req = 4'b0100;
      step(); step(); step();
      rst = 1'b1; req = '0;
      step();
      rst = 1'b0;
      chk("mr_gnt", 32'(gnt), 32'h0);
      chk("mr_busy", 32'(busy), 32'h0);
      chk("mr_ack", 32'(ack), 32'h0);
      chk("mr_res", 32'(res), 32'h0);
      req = 4'b1001;
      txn(1, 16'h7777, 1'b0, 1'b0, 4'b0010, g, es, o, a, e, r, nc, a2);
      chk("mr_ptr0", 32'(g), 32'h1);
      txn(1, 16'h8888, 1'b0, 1'b0, 4'b0000, g, es, o, a, e, r, nc, a2);
      chk("mr_next", 32'(a), 32'h2);
      chk("mr_nres", 32'(r), 32'h8888);

      // random traffic
      pend = '0;
      repeat (3000) begin
         rst = ($urandom_range(0, 299) == 0);
         for (int i = 0; i < N; i++) begin
            if (ack[i]) begin
               pend[i] = 1'b0; req[i] = 1'b0;
            end else if (!pend[i] && $urandom_range(0, 3) == 0) begin
               pend[i] = 1'b1; req[i] = 1'b1;
               opnd[i*DW +: DW] = DW'($urandom);
            end else if (pend[i] && $urandom_range(0, 199) == 0) begin
               pend[i] = 1'b0; req[i] = 1'b0;
            end
         end
         engDone = ($urandom_range(0, 2) == 0);
         engRes = RW'($urandom);
         step();
      end
      rst = 1'b0; req = '0; engDone = 1'b0;
      step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
